dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: DBITS, 16, data width; ABITS, 12, word-address width of the memory array; MAX_BURST, 4, max consecutive grants to one requester while the other waits.
REQ-002 Port CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port RESET  input  1  synchronous, active-high reset.
REQ-004 Ports CPU_REQ/DMA_REQ  input  1  access request, held until granted.
REQ-005 Ports CPU_WE/DMA_WE  input  1  1=write, 0=read.
REQ-006 Ports CPU_ADDR/DMA_ADDR  input  DBITS  byte address.
REQ-007 Ports CPU_DIN/DMA_DIN  input  DBITS  write data.
REQ-008 Ports CPU_GNT/DMA_GNT  output  1  access issued this cycle.
REQ-009 Ports CPU_RVALID/DMA_RVALID  output  1  read data valid this cycle.
REQ-010 Ports CPU_DOUT/DMA_DOUT  output  DBITS  read data.
REQ-011 Port MEM_ADDR  output  ABITS  word address to the memory array.
REQ-012 Port MEM_DIN  output  DBITS  write data to the memory array.
REQ-013 Port MEM_WE  output  1  memory array write enable.
REQ-014 Port MEM_DOUT  input  DBITS  memory array read data, valid one cycle after the address.

Function
REQ-015 States SHALL be IDLE, CPU_OWN, DMA_OWN, held in a register; the state names the owner of the previous cycle.
REQ-016 At most one GNT SHALL be high per cycle; GNT is combinational from the REQ inputs and registered state, in the same cycle as the request.
REQ-017 A single requester SHALL be granted in the cycle it requests.
REQ-018 Both requesting from IDLE: CPU SHALL win.
REQ-019 Both requesting from X_OWN: the owner SHALL keep the grant while its burst count is below MAX_BURST, otherwise the other requester is granted.
REQ-020 The burst counter SHALL reset to 1 on an owner change and increment on a repeat grant to the same owner, saturating at MAX_BURST.
REQ-021 No request: next state SHALL be IDLE and the burst counter SHALL clear to 0.
REQ-022 Granted cycle: MEM_ADDR SHALL be ADDR[ABITS:1] and MEM_DIN SHALL be the winner's DIN.
REQ-023 MEM_WE SHALL be GNT && WE && (ADDR[DBITS-1:13]==0); a write outside the array is granted and dropped.
REQ-024 A granted read SHALL assert that requester's RVALID exactly one cycle later; there is no back-pressure.
REQ-025 DOUT SHALL be MEM_DOUT for an in-range read and 16'hDEAD for an out-of-range read, using the range bit registered at grant.
REQ-026 DOUT SHALL hold its last value when RVALID is low.
REQ-027 Non-granted cycle: MEM_WE SHALL be 0; MEM_ADDR and MEM_DIN are don't-care.
REQ-028 A requester granted back-to-back SHALL receive one RVALID per granted read, in order, one per cycle.
REQ-029 Granted writes SHALL never produce RVALID.

Reset
REQ-030 RESET high at a clock edge SHALL force state IDLE, burst counter 0, and the pending-read flags clear.
REQ-031 During reset, GNT, RVALID and MEM_WE SHALL be 0 and DOUT SHALL be 0.
REQ-032 A read granted in the cycle before RESET SHALL NOT produce RVALID after reset.
REQ-033 The first cycle after RESET deasserts SHALL arbitrate as from IDLE.

Verification
REQ-034 CPU read addr 16'h0200 alone, MEM_DOUT=16'h1234 -> CPU_GNT same cycle, MEM_ADDR=12'h100, CPU_RVALID next cycle with CPU_DOUT=16'h1234.
REQ-035 CPU and DMA request together from IDLE, both held 10 cycles -> grant pattern CPU x4, DMA x4, CPU x2; never two GNT high in one cycle.
REQ-036 DMA write 16'hBEEF to addr 16'hFFF8 -> DMA_GNT=1, MEM_WE=0, no RVALID; then DMA read 16'hFFF2 -> DMA_RVALID next cycle, DMA_DOUT=16'hDEAD.
REQ-037 CPU write addr 16'h0010 data 16'h00AA -> MEM_WE=1, MEM_ADDR=12'h008, MEM_DIN=16'h00AA, no RVALID.
REQ-038 CPU read granted, RESET asserted next edge -> CPU_RVALID stays 0, state IDLE, DMA-only request after reset granted immediately.
REQ-039 DMA alone for 6 cycles, CPU request arrives in cycle 3 -> CPU granted in cycle 5 (DMA burst 4 reached), DMA regains grant the cycle after.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port word-addressed data memory.
// Grants are decided combinationally in the request cycle. Read data returns one
// cycle later. Bursts are bounded so a waiting requester is never starved.
module dmem_arbiter #(
  parameter int unsigned DBITS     = 16,
  parameter int unsigned ABITS     = 12,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CPU_REQ,
  input  logic             CPU_WE,
  input  logic [DBITS-1:0] CPU_ADDR,
  input  logic [DBITS-1:0] CPU_DIN,
  output logic             CPU_GNT,
  output logic             CPU_RVALID,
  output logic [DBITS-1:0] CPU_DOUT,
  input  logic             DMA_REQ,
  input  logic             DMA_WE,
  input  logic [DBITS-1:0] DMA_ADDR,
  input  logic [DBITS-1:0] DMA_DIN,
  output logic             DMA_GNT,
  output logic             DMA_RVALID,
  output logic [DBITS-1:0] DMA_DOUT,
  output logic [ABITS-1:0] MEM_ADDR,
  output logic [DBITS-1:0] MEM_DIN,
  output logic             MEM_WE,
  input  logic [DBITS-1:0] MEM_DOUT
);

  localparam int unsigned     BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0]   BURST_ONE = BW'(1);
  localparam logic [DBITS-1:0] OOB_DATA = DBITS'(16'hDEAD);

  // State names the owner of the previous cycle.
  typedef enum logic [1:0] {IDLE, CPU_OWN, DMA_OWN} state_t;

  state_t             state;
  logic [BW-1:0]      burst;
  logic               cpu_pend;
  logic               dma_pend;
  logic               rd_oob;
  logic [DBITS-1:0]   cpu_dout_q;
  logic [DBITS-1:0]   dma_dout_q;

  logic               cpu_win;
  logic               dma_win;
  logic [DBITS-1:0]   sel_addr;
  logic [DBITS-1:0]   sel_din;
  logic               sel_we;
  logic               in_range;
  logic [DBITS-1:0]   rd_data;
  logic               unused_addr_lsb;

  // Arbitration: CPU wins from IDLE; the owner keeps the grant until its burst is spent.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (!RESET) begin
      case (state)
        CPU_OWN: begin
          if (CPU_REQ && (!DMA_REQ || (burst < BURST_MAX))) cpu_win = 1'b1;
          else if (DMA_REQ)                                 dma_win = 1'b1;
        end
        DMA_OWN: begin
          if (DMA_REQ && (!CPU_REQ || (burst < BURST_MAX))) dma_win = 1'b1;
          else if (CPU_REQ)                                 cpu_win = 1'b1;
        end
        default: begin
          if (CPU_REQ)      cpu_win = 1'b1;
          else if (DMA_REQ) dma_win = 1'b1;
        end
      endcase
    end
  end

  // Memory-side mux driven by the winner; writes above the array are dropped.
  always_comb begin
    sel_addr = dma_win ? DMA_ADDR : CPU_ADDR;
    sel_din  = dma_win ? DMA_DIN  : CPU_DIN;
    sel_we   = dma_win ? DMA_WE   : CPU_WE;
    in_range = (sel_addr[DBITS-1:ABITS+1] == '0);
    MEM_ADDR = sel_addr[ABITS:1];
    MEM_DIN  = sel_din;
    MEM_WE   = (cpu_win || dma_win) && sel_we && in_range;
  end

  assign unused_addr_lsb = sel_addr[0];

  assign CPU_GNT    = cpu_win;
  assign DMA_GNT    = dma_win;
  assign CPU_RVALID = cpu_pend && !RESET;
  assign DMA_RVALID = dma_pend && !RESET;

  // Read return data: memory word for in-range reads, a marker value otherwise.
  always_comb begin
    rd_data  = rd_oob ? OOB_DATA : MEM_DOUT;
    CPU_DOUT = RESET ? '0 : (CPU_RVALID ? rd_data : cpu_dout_q);
    DMA_DOUT = RESET ? '0 : (DMA_RVALID ? rd_data : dma_dout_q);
  end

  // Owner/burst tracking, pending-read flags and held read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      burst      <= '0;
      cpu_pend   <= 1'b0;
      dma_pend   <= 1'b0;
      rd_oob     <= 1'b0;
      cpu_dout_q <= '0;
      dma_dout_q <= '0;
    end else begin
      if (cpu_win) begin
        state <= CPU_OWN;
        if (state == CPU_OWN) burst <= (burst < BURST_MAX) ? burst + BURST_ONE : burst;
        else                  burst <= BURST_ONE;
      end else if (dma_win) begin
        state <= DMA_OWN;
        if (state == DMA_OWN) burst <= (burst < BURST_MAX) ? burst + BURST_ONE : burst;
        else                  burst <= BURST_ONE;
      end else begin
        state <= IDLE;
        burst <= '0;
      end
      cpu_pend <= cpu_win && !CPU_WE;
      dma_pend <= dma_win && !DMA_WE;
      rd_oob   <= !in_range;
      if (CPU_RVALID) cpu_dout_q <= rd_data;
      if (DMA_RVALID) dma_dout_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single accesses, burst fairness,
// out-of-range handling and reset cancelling an in-flight read.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CPU_REQ, CPU_WE, DMA_REQ, DMA_WE;
  logic [15:0] CPU_ADDR, CPU_DIN, DMA_ADDR, DMA_DIN;
  logic        CPU_GNT, CPU_RVALID, DMA_GNT, DMA_RVALID;
  logic [15:0] CPU_DOUT, DMA_DOUT;
  logic [11:0] MEM_ADDR;
  logic [15:0] MEM_DIN;
  logic        MEM_WE;
  logic [15:0] MEM_DOUT;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DBITS(16), .ABITS(12), .MAX_BURST(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
    .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_DOUT(CPU_DOUT),
    .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR), .DMA_DIN(DMA_DIN),
    .DMA_GNT(DMA_GNT), .DMA_RVALID(DMA_RVALID), .DMA_DOUT(DMA_DOUT),
    .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_WE(MEM_WE), .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
    DMA_REQ = 1'b0; DMA_WE = 1'b0; DMA_ADDR = '0; DMA_DIN = '0;
  endtask

  bit exp_cpu [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  bit exp_dma39 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  bit prev_c, prev_d;

  initial begin
    // Reset with a request present: nothing may be granted or written.
    RESET = 1'b1;
    idle_inputs();
    MEM_DOUT = 16'h0000;
    tick();
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 16'h0010; CPU_DIN = 16'h1111;
    #1;
    check("rst_cpu_gnt", CPU_GNT, 0);
    check("rst_dma_gnt", DMA_GNT, 0);
    check("rst_mem_we", MEM_WE, 0);
    check("rst_cpu_rvalid", CPU_RVALID, 0);
    check("rst_dma_rvalid", DMA_RVALID, 0);
    check("rst_cpu_dout", CPU_DOUT, 0);
    check("rst_dma_dout", DMA_DOUT, 0);

    // Single CPU read.
    tick();
    RESET = 1'b0;
    idle_inputs();
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 16'h0200;
    #1;
    check("rd_cpu_gnt", CPU_GNT, 1);
    check("rd_dma_gnt", DMA_GNT, 0);
    check("rd_mem_addr", MEM_ADDR, 12'h100);
    check("rd_mem_we", MEM_WE, 0);
    tick();
    idle_inputs(); MEM_DOUT = 16'h1234;
    #1;
    check("rd_cpu_rvalid", CPU_RVALID, 1);
    check("rd_cpu_dout", CPU_DOUT, 16'h1234);
    check("rd_dma_rvalid", DMA_RVALID, 0);
    tick();
    MEM_DOUT = 16'h5555;
    #1;
    check("rd_rvalid_once", CPU_RVALID, 0);
    check("rd_dout_hold", CPU_DOUT, 16'h1234);

    // CPU in-range write.
    tick();
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 16'h0010; CPU_DIN = 16'h00AA;
    #1;
    check("wr_cpu_gnt", CPU_GNT, 1);
    check("wr_mem_we", MEM_WE, 1);
    check("wr_mem_addr", MEM_ADDR, 12'h008);
    check("wr_mem_din", MEM_DIN, 16'h00AA);
    tick();
    idle_inputs();
    #1;
    check("wr_no_rvalid", CPU_RVALID, 0);

    // DMA out-of-range write then read.
    tick();
    DMA_REQ = 1'b1; DMA_WE = 1'b1; DMA_ADDR = 16'hFFF8; DMA_DIN = 16'hBEEF;
    #1;
    check("oob_wr_gnt", DMA_GNT, 1);
    check("oob_wr_cpu_gnt", CPU_GNT, 0);
    check("oob_wr_mem_we", MEM_WE, 0);
    tick();
    DMA_WE = 1'b0; DMA_ADDR = 16'hFFF2;
    #1;
    check("oob_rd_gnt", DMA_GNT, 1);
    check("oob_wr_no_rvalid", DMA_RVALID, 0);
    tick();
    idle_inputs(); MEM_DOUT = 16'h7777;
    #1;
    check("oob_rd_rvalid", DMA_RVALID, 1);
    check("oob_rd_dout", DMA_DOUT, 16'hDEAD);
    tick();
    #1;
    check("oob_rd_rvalid_once", DMA_RVALID, 0);
    check("oob_dout_hold", DMA_DOUT, 16'hDEAD);

    // Both requesting for 10 cycles: CPU x4, DMA x4, CPU x2, reads returned in order.
    prev_c = 1'b0; prev_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 16'h0002;
      DMA_REQ = 1'b1; DMA_WE = 1'b0; DMA_ADDR = 16'h0004;
      MEM_DOUT = 16'h1000 + 16'(i);
      #1;
      check($sformatf("burst_cpu_gnt_%0d", i), CPU_GNT, exp_cpu[i]);
      check($sformatf("burst_dma_gnt_%0d", i), DMA_GNT, !exp_cpu[i]);
      check($sformatf("burst_one_hot_%0d", i), CPU_GNT && DMA_GNT, 0);
      check($sformatf("burst_cpu_rvalid_%0d", i), CPU_RVALID, prev_c);
      check($sformatf("burst_dma_rvalid_%0d", i), DMA_RVALID, prev_d);
      if (prev_c) check($sformatf("burst_cpu_dout_%0d", i), CPU_DOUT, 16'h1000 + 16'(i));
      if (prev_d) check($sformatf("burst_dma_dout_%0d", i), DMA_DOUT, 16'h1000 + 16'(i));
      prev_c = exp_cpu[i];
      prev_d = !exp_cpu[i];
    end
    tick();
    idle_inputs();
    #1;
    check("burst_tail_cpu_rvalid", CPU_RVALID, 1);
    check("burst_tail_dma_rvalid", DMA_RVALID, 0);

    // DMA alone for 6 cycles, CPU requests from cycle 3 until granted.
    for (int c = 1; c <= 6; c++) begin
      tick();
      DMA_REQ = 1'b1; DMA_WE = 1'b1; DMA_ADDR = 16'h0040; DMA_DIN = 16'h00D0;
      CPU_REQ = (c >= 3 && c <= 5); CPU_WE = 1'b1; CPU_ADDR = 16'h0020; CPU_DIN = 16'h00C0;
      #1;
      check($sformatf("fair_dma_gnt_%0d", c), DMA_GNT, exp_dma39[c-1]);
      check($sformatf("fair_cpu_gnt_%0d", c), CPU_GNT, !exp_dma39[c-1]);
      check($sformatf("fair_mem_we_%0d", c), MEM_WE, 1);
    end

    // CPU read granted, reset follows: the read must not return.
    tick();
    idle_inputs();
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 16'h0100;
    #1;
    check("rstrd_cpu_gnt", CPU_GNT, 1);
    tick();
    idle_inputs(); RESET = 1'b1; MEM_DOUT = 16'h9999;
    #1;
    check("rstrd_rvalid_in_reset", CPU_RVALID, 0);
    check("rstrd_cpu_dout_reset", CPU_DOUT, 0);
    tick();
    RESET = 1'b0;
    DMA_REQ = 1'b1; DMA_WE = 1'b0; DMA_ADDR = 16'h0300;
    #1;
    check("rstrd_rvalid_after", CPU_RVALID, 0);
    check("rstrd_dma_gnt", DMA_GNT, 1);
    check("rstrd_cpu_gnt", CPU_GNT, 0);
    check("rstrd_mem_addr", MEM_ADDR, 12'h180);
    tick();
    idle_inputs(); MEM_DOUT = 16'hABCD;
    #1;
    check("rstrd_dma_rvalid", DMA_RVALID, 1);
    check("rstrd_dma_dout", DMA_DOUT, 16'hABCD);
    check("rstrd_cpu_rvalid_late", CPU_RVALID, 0);
    check("rstrd_cpu_dout_cleared", CPU_DOUT, 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
